axi_tdd_ng_frame_seq: RTL and testbench
=======================================

# axi_tdd_ng_frame_seq

Frame sequencer for the TDD engine: consumes the single-cycle sync pulse from the TDD sync generator and sequences the frame timebase. It arms on enable, waits for a sync, applies a startup delay, then runs a burst of fixed-length frames, driving the frame counter that downstream channel comparators use. It also handles sync-triggered mid-frame restarts.

## Interface
Parameters:
- COUNT_WIDTH, 32, width of frame/delay counter and length registers
- BURST_WIDTH, 32, width of burst count and frame index

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- tdd_enable  in  1  level; 0 forces IDLE next cycle
- tdd_sync  in  1  single-cycle sync pulse from sync generator
- tdd_sync_rst  in  1  1: sync while WAITING/RUNNING restarts sequence
- tdd_startup_delay  in  COUNT_WIDTH  cycles between accepted sync and first frame
- tdd_frame_length  in  COUNT_WIDTH  frame length in cycles; 0 treated as 1
- tdd_burst_count  in  BURST_WIDTH  frames per burst; 0 = infinite
- tdd_counter  out  COUNT_WIDTH  current delay/frame counter
- tdd_cstate  out  2  0 IDLE, 1 ARMED, 2 WAITING, 3 RUNNING
- tdd_frame_start  out  1  high in first cycle of each frame (counter 0, RUNNING)
- tdd_endof_frame  out  1  high in last cycle of each frame (counter L-1, RUNNING)

## Operation
- All outputs registered; reset value 0 for every output, state IDLE.
- Config latch: tdd_startup_delay, tdd_frame_length, tdd_burst_count captured into shadow regs (D, L, N) whenever a sync is accepted; live inputs otherwise ignored.
- Internal frame index F (BURST_WIDTH), cleared on sync accept.
- IDLE: counter 0; tdd_enable=1 -> ARMED.
- ARMED: counter 0; tdd_sync=1 -> latch; D=0 -> RUNNING, else WAITING; counter 0.
- WAITING: counter increments; at counter==D-1 -> RUNNING, counter 0.
- RUNNING: counter increments; at counter==L-1: endof_frame, counter 0, F+1; if N!=0 and F+1==N -> ARMED (one burst per sync), else stay RUNNING.
- tdd_sync in WAITING/RUNNING with tdd_sync_rst=1: re-latch config, F=0, counter 0, go WAITING (D!=0) or RUNNING (D=0). With tdd_sync_rst=0: ignored.
- Sync restart coinciding with last frame cycle: endof_frame still asserted that cycle; restart wins for next state; burst-complete ignored.
- tdd_enable=0 in any state: next cycle IDLE, counter 0, pulses 0; overrides simultaneous sync.
- reset overrides everything, same next-cycle effect as tdd_enable=0.
- Counter never exceeds max(L,1)-1 or D-1; no wrap. L=0 behaves as L=1 (frame_start and endof_frame every cycle).

## Timing
- Sync accepted at cycle T (ARMED): D=0 -> T+1 RUNNING, counter 0, frame_start 1.
- D>0: T+1..T+D WAITING counter 0..D-1; T+D+1 RUNNING counter 0, frame_start 1.
- Frame: L cycles, counter 0..L-1; next frame_start immediately follows endof_frame (no gap).
- Burst end: cycle after N-th endof_frame -> ARMED, counter 0; a sync in that ARMED cycle is accepted (min 1 cycle ARMED).
- IDLE->ARMED: 1 cycle after tdd_enable rises; sync during IDLE ignored.
- tdd_cstate, tdd_counter, pulses all update on the same edge.

## Configuration
- AXI_TDD_NG_FRAME_SEQ_STATUS_EN defined: adds outputs tdd_frame_index (BURST_WIDTH, F registered, reset 0) and tdd_sync_ovf (1, sticky; set when tdd_sync arrives in WAITING/RUNNING with tdd_sync_rst=0; cleared only by reset or tdd_enable=0).
- Undefined: those ports and logic absent; all other behaviour identical.

## Test plan
- D=0, L=4, N=2, sync at T -> RUNNING T+1; endof_frame at T+4, T+8; ARMED at T+9; frame_start at T+1, T+5.
- D=3, L=5, N=0 -> WAITING counter 0,1,2 at T+1..T+3; frame_start T+4; frames repeat indefinitely every 5 cycles.
- L=6 running, sync with tdd_sync_rst=1 at counter 3 -> counter 0 next cycle, frame_start 1, F=0; with tdd_sync_rst=0 -> ignored, tdd_sync_ovf=1 (macro on).
- Change tdd_frame_length 4->7 mid-burst -> frames stay 4 until next accepted sync, then 7.
- tdd_enable dropped mid-frame with simultaneous sync -> next cycle IDLE, counter 0; re-enable -> ARMED after 1 cycle.
- L=0, N=3 -> frame_start and endof_frame high 3 consecutive cycles, then ARMED.

Source files
------------

// File: rtl/axi_tdd_ng_frame_seq.sv
// -----------------------------------------------------------------------------
// axi_tdd_ng_frame_seq
//
// Frame sequencer for the TDD engine. Arms on enable, waits for a sync pulse,
// runs an optional startup delay and then a burst of fixed-length frames,
// driving the frame counter used by downstream channel comparators. A sync
// seen while WAITING/RUNNING restarts the sequence when tdd_sync_rst is set.
//
// Optional feature macro: AXI_TDD_NG_FRAME_SEQ_STATUS_EN
//   When defined, adds tdd_frame_index (current frame index) and
//   tdd_sync_ovf (sticky flag for syncs that were ignored while busy).
//
// Ports:
//   clk                in   core clock
//   reset              in   synchronous, active-high reset
//   tdd_enable         in   level enable; low forces IDLE on the next cycle
//   tdd_sync           in   single-cycle sync pulse
//   tdd_sync_rst       in   allow a sync to restart a WAITING/RUNNING sequence
//   tdd_startup_delay  in   cycles between accepted sync and first frame
//   tdd_frame_length   in   frame length in cycles (0 behaves as 1)
//   tdd_burst_count    in   frames per burst (0 = infinite)
//   tdd_counter        out  current delay/frame counter
//   tdd_cstate         out  0 IDLE, 1 ARMED, 2 WAITING, 3 RUNNING
//   tdd_frame_start    out  first cycle of each frame
//   tdd_endof_frame    out  last cycle of each frame
//   tdd_frame_index    out  frame index F            (status build only)
//   tdd_sync_ovf       out  sticky ignored-sync flag (status build only)
// -----------------------------------------------------------------------------
module axi_tdd_ng_frame_seq #(
   parameter int COUNT_WIDTH = 32,
   parameter int BURST_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   tdd_enable,
   input  logic                   tdd_sync,
   input  logic                   tdd_sync_rst,
   input  logic [COUNT_WIDTH-1:0] tdd_startup_delay,
   input  logic [COUNT_WIDTH-1:0] tdd_frame_length,
   input  logic [BURST_WIDTH-1:0] tdd_burst_count,
   output logic [COUNT_WIDTH-1:0] tdd_counter,
   output logic [1:0]             tdd_cstate,
   output logic                   tdd_frame_start,
   output logic                   tdd_endof_frame
`ifdef AXI_TDD_NG_FRAME_SEQ_STATUS_EN
   ,
   output logic [BURST_WIDTH-1:0] tdd_frame_index,
   output logic                   tdd_sync_ovf
`endif
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ARMED   = 2'd1;
   localparam logic [1:0] WAITING = 2'd2;
   localparam logic [1:0] RUNNING = 2'd3;

   localparam logic [COUNT_WIDTH-1:0] C_ONE = 1;
   localparam logic [BURST_WIDTH-1:0] B_ONE = 1;

   // shadow configuration, captured on every accepted sync
   logic [COUNT_WIDTH-1:0] delay_q;
   logic [COUNT_WIDTH-1:0] length_q;
   logic [BURST_WIDTH-1:0] burst_q;
   logic [BURST_WIDTH-1:0] frame_q;

   logic [1:0]             nxt_state;
   logic [COUNT_WIDTH-1:0] nxt_counter;
   logic [BURST_WIDTH-1:0] nxt_frame;
   logic [BURST_WIDTH-1:0] frame_inc;
   logic [COUNT_WIDTH-1:0] len_eff;
   logic [COUNT_WIDTH-1:0] nxt_len_eff;
   logic                   latch;
   logic                   restart;
   logic                   nxt_fs;
   logic                   nxt_ef;

   assign restart   = tdd_sync & tdd_sync_rst;
   assign frame_inc = frame_q + B_ONE;
   assign len_eff   = (length_q == '0) ? C_ONE : length_q;

   always_comb begin
      nxt_state   = tdd_cstate;
      nxt_counter = tdd_counter;
      nxt_frame   = frame_q;
      latch       = 1'b0;

      case (tdd_cstate)
         IDLE: begin
            nxt_counter = '0;
            nxt_state   = ARMED;
         end
         ARMED: begin
            nxt_counter = '0;
            latch       = tdd_sync;
         end
         WAITING: begin
            if (restart) begin
               latch = 1'b1;
            end else if (tdd_counter == delay_q - C_ONE) begin
               nxt_state   = RUNNING;
               nxt_counter = '0;
            end else begin
               nxt_counter = tdd_counter + C_ONE;
            end
         end
         default: begin // RUNNING
            if (restart) begin
               latch = 1'b1;
            end else if (tdd_counter == len_eff - C_ONE) begin
               nxt_counter = '0;
               nxt_frame   = frame_inc;
               if (burst_q != '0 && frame_inc == burst_q) nxt_state = ARMED;
            end else begin
               nxt_counter = tdd_counter + C_ONE;
            end
         end
      endcase

      // an accepted sync (fresh or restart) takes precedence over burst end
      if (latch) begin
         nxt_frame   = '0;
         nxt_counter = '0;
         nxt_state   = (tdd_startup_delay == '0) ? RUNNING : WAITING;
      end

      // disable overrides everything, including a simultaneous sync
      if (!tdd_enable) begin
         latch       = 1'b0;
         nxt_state   = IDLE;
         nxt_counter = '0;
         nxt_frame   = frame_q;
      end

      // pulses are derived from the next cycle's state so they stay aligned
      // with the registered counter, using the length that will be in force
      nxt_len_eff = latch ? ((tdd_frame_length == '0) ? C_ONE : tdd_frame_length)
                          : len_eff;
      nxt_fs = (nxt_state == RUNNING) && (nxt_counter == '0);
      nxt_ef = (nxt_state == RUNNING) && (nxt_counter == nxt_len_eff - C_ONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tdd_cstate      <= IDLE;
         tdd_counter     <= '0;
         tdd_frame_start <= 1'b0;
         tdd_endof_frame <= 1'b0;
         frame_q         <= '0;
         delay_q         <= '0;
         length_q        <= '0;
         burst_q         <= '0;
      end else begin
         tdd_cstate      <= nxt_state;
         tdd_counter     <= nxt_counter;
         tdd_frame_start <= nxt_fs;
         tdd_endof_frame <= nxt_ef;
         frame_q         <= nxt_frame;
         if (latch) begin
            delay_q  <= tdd_startup_delay;
            length_q <= tdd_frame_length;
            burst_q  <= tdd_burst_count;
         end
      end
   end

`ifdef AXI_TDD_NG_FRAME_SEQ_STATUS_EN
   logic sync_ignored;

   assign sync_ignored = tdd_sync & ~tdd_sync_rst &
                         ((tdd_cstate == WAITING) || (tdd_cstate == RUNNING));
   assign tdd_frame_index = frame_q;

   always_ff @(posedge clk) begin
      if (reset || !tdd_enable) begin
         tdd_sync_ovf <= 1'b0;
      end else if (sync_ignored) begin
         tdd_sync_ovf <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_axi_tdd_ng_frame_seq.sv
// -----------------------------------------------------------------------------
// tb_axi_tdd_ng_frame_seq
//
// Self-checking bench for axi_tdd_ng_frame_seq. The reference model tracks
// only the mode (idle / armed / active), the cycle a sync was accepted and the
// latched configuration; outputs in the active mode are derived from elapsed
// time with division/modulo. Directed sequences pin the model with literal
// expectations, then a long randomized run is compared every cycle.
// -----------------------------------------------------------------------------
module tb_axi_tdd_ng_frame_seq;

   localparam int CW = 16;
   localparam int BW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          tdd_enable;
   logic          tdd_sync;
   logic          tdd_sync_rst;
   logic [CW-1:0] tdd_startup_delay;
   logic [CW-1:0] tdd_frame_length;
   logic [BW-1:0] tdd_burst_count;
   logic [CW-1:0] tdd_counter;
   logic [1:0]    tdd_cstate;
   logic          tdd_frame_start;
   logic          tdd_endof_frame;
`ifdef AXI_TDD_NG_FRAME_SEQ_STATUS_EN
   logic [BW-1:0] tdd_frame_index;
   logic          tdd_sync_ovf;
`endif

   axi_tdd_ng_frame_seq #(.COUNT_WIDTH(CW), .BURST_WIDTH(BW)) dut (
      .clk               (clk),
      .reset             (reset),
      .tdd_enable        (tdd_enable),
      .tdd_sync          (tdd_sync),
      .tdd_sync_rst      (tdd_sync_rst),
      .tdd_startup_delay (tdd_startup_delay),
      .tdd_frame_length  (tdd_frame_length),
      .tdd_burst_count   (tdd_burst_count),
      .tdd_counter       (tdd_counter),
      .tdd_cstate        (tdd_cstate),
      .tdd_frame_start   (tdd_frame_start),
      .tdd_endof_frame   (tdd_endof_frame)
`ifdef AXI_TDD_NG_FRAME_SEQ_STATUS_EN
      ,
      .tdd_frame_index   (tdd_frame_index),
      .tdd_sync_ovf      (tdd_sync_ovf)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // reference model state
   int     m_mode = 0;       // 0 idle, 1 armed, 2 active (waiting or running)
   longint cyc    = 0;
   longint t_acc  = 0;
   longint m_d = 0, m_l = 0, m_n = 0;
   bit     m_ovf  = 1'b0;
   longint m_fidx = 0;
   longint e_st = 0, e_cnt = 0;
   bit     e_fs = 1'b0, e_ef = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // derive expected outputs for the current cycle from elapsed time
   task automatic model_eval();
      longint p, q, le, fr;
      e_st = 0; e_cnt = 0; e_fs = 1'b0; e_ef = 1'b0;
      if (m_mode == 1) begin
         e_st = 1;
      end else if (m_mode == 2) begin
         p = cyc - t_acc - 1;
         if (p < m_d) begin
            e_st = 2; e_cnt = p; m_fidx = 0;
         end else begin
            q  = p - m_d;
            le = (m_l == 0) ? 1 : m_l;
            fr = q / le;
            if (m_n != 0 && fr >= m_n) begin
               m_mode = 1; e_st = 1; m_fidx = m_n;
            end else begin
               e_st  = 3;
               e_cnt = q % le;
               e_fs  = (e_cnt == 0);
               e_ef  = (e_cnt == le - 1);
               m_fidx = fr;
            end
         end
      end
   endtask

   task automatic accept();
      m_d = tdd_startup_delay; m_l = tdd_frame_length; m_n = tdd_burst_count;
      t_acc = cyc; m_mode = 2;
   endtask

   // decide next mode from the inputs presented during the current cycle
   task automatic model_update();
      if (reset || !tdd_enable) begin
         m_mode = 0; m_ovf = 1'b0;
         if (reset) m_fidx = 0;
      end else if (e_st == 0) begin
         m_mode = 1;
      end else if (e_st == 1) begin
         if (tdd_sync) accept();
      end else if (tdd_sync) begin
         if (tdd_sync_rst) accept();
         else m_ovf = 1'b1;
      end
   endtask

   task automatic tick();
      model_update();
      @(posedge clk);
      #1;
      cyc++;
      model_eval();
      chk("cstate", tdd_cstate, e_st);
      chk("counter", tdd_counter, e_cnt);
      chk("frame_start", tdd_frame_start, e_fs);
      chk("endof_frame", tdd_endof_frame, e_ef);
`ifdef AXI_TDD_NG_FRAME_SEQ_STATUS_EN
      chk("frame_index", tdd_frame_index, m_fidx & 255);
      chk("sync_ovf", tdd_sync_ovf, m_ovf);
`endif
   endtask

   task automatic set_cfg(input int d, input int l, input int n);
      tdd_startup_delay = CW'(d);
      tdd_frame_length  = CW'(l);
      tdd_burst_count   = BW'(n);
   endtask

   initial begin
      reset = 1'b1; tdd_enable = 1'b0; tdd_sync = 1'b0; tdd_sync_rst = 1'b0;
      set_cfg(0, 0, 0);
      model_eval();
      repeat (3) tick();
      chk("lit_reset_state", tdd_cstate, 0);
      chk("lit_reset_counter", tdd_counter, 0);
      chk("lit_reset_pulses", {tdd_frame_start, tdd_endof_frame}, 0);

      reset = 1'b0; tdd_enable = 1'b1;
      tick();
      chk("lit_armed_after_enable", tdd_cstate, 1);

      // D=0 L=4 N=2; live length changed to 7 right after the sync
      tdd_sync = 1'b1; set_cfg(0, 4, 2);
      for (int k = 1; k <= 9; k++) begin
         tick();
         tdd_sync = 1'b0; set_cfg(5, 7, 1);
         chk("lit_b1_fs", tdd_frame_start, (k == 1 || k == 5));
         chk("lit_b1_ef", tdd_endof_frame, (k == 4 || k == 8));
         chk("lit_b1_st", tdd_cstate, (k == 9) ? 1 : 3);
      end

      // next sync picks up length 7, one frame
      tdd_sync = 1'b1; set_cfg(0, 7, 1);
      for (int k = 1; k <= 8; k++) begin
         tick();
         tdd_sync = 1'b0;
         chk("lit_b2_ef", tdd_endof_frame, (k == 7));
         chk("lit_b2_st", tdd_cstate, (k == 8) ? 1 : 3);
      end

      // L=0 N=3: three single-cycle frames
      tdd_sync = 1'b1; set_cfg(0, 0, 3);
      for (int k = 1; k <= 4; k++) begin
         tick();
         tdd_sync = 1'b0;
         chk("lit_l0_fs", tdd_frame_start, (k <= 3));
         chk("lit_l0_ef", tdd_endof_frame, (k <= 3));
         chk("lit_l0_st", tdd_cstate, (k == 4) ? 1 : 3);
      end

      // D=3 L=5 N=0: startup delay then endless frames
      tdd_sync = 1'b1; set_cfg(3, 5, 0);
      for (int k = 1; k <= 9; k++) begin
         tick();
         tdd_sync = 1'b0;
         chk("lit_d3_st", tdd_cstate, (k <= 3) ? 2 : 3);
         chk("lit_d3_cnt", tdd_counter, (k <= 3) ? k - 1 : (k - 4) % 5);
         chk("lit_d3_fs", tdd_frame_start, (k == 4 || k == 9));
      end

      // restart into L=6, then restart again at counter 3
      tdd_sync = 1'b1; tdd_sync_rst = 1'b1; set_cfg(0, 6, 0);
      tick();
      tdd_sync = 1'b0;
      chk("lit_rst_cnt0", tdd_counter, 0);
      chk("lit_rst_fs", tdd_frame_start, 1);
      repeat (3) tick();
      chk("lit_rst_cnt3", tdd_counter, 3);
      tdd_sync = 1'b1;
      tick();
      tdd_sync = 1'b0;
      chk("lit_mid_restart_cnt", tdd_counter, 0);
      chk("lit_mid_restart_fs", tdd_frame_start, 1);
`ifdef AXI_TDD_NG_FRAME_SEQ_STATUS_EN
      chk("lit_mid_restart_f", tdd_frame_index, 0);
`endif
      tick();
      tdd_sync = 1'b1; tdd_sync_rst = 1'b0;
      tick();
      tdd_sync = 1'b0;
      chk("lit_ignored_sync_cnt", tdd_counter, 2);
`ifdef AXI_TDD_NG_FRAME_SEQ_STATUS_EN
      chk("lit_sync_ovf", tdd_sync_ovf, 1);
`endif

      // enable drop with a simultaneous sync, then re-enable
      tdd_enable = 1'b0; tdd_sync = 1'b1; tdd_sync_rst = 1'b1;
      tick();
      tdd_sync = 1'b0;
      chk("lit_disable_st", tdd_cstate, 0);
      chk("lit_disable_cnt", tdd_counter, 0);
      tdd_enable = 1'b1;
      tick();
      chk("lit_reenable_st", tdd_cstate, 1);

      // randomized run against the model
      for (int i = 0; i < 4000; i++) begin
         reset        = ($urandom_range(199) == 0);
         tdd_enable   = ($urandom_range(49) != 0);
         tdd_sync     = ($urandom_range(5) == 0);
         tdd_sync_rst = $urandom_range(1) == 1;
         set_cfg(int'($urandom_range(4)), int'($urandom_range(6)), int'($urandom_range(3)));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
